up_counter_sync: RTL and testbench
==================================

Name: up_counter_sync

Overview:
Free-running binary up-counter. Increments by one on every rising clock edge and wraps modulo 2^WIDTH. Synchronous active-high reset returns it to its initial value. Serves as a basic timebase/sequencer primitive; it also flags when the count is at its maximum and when a roll-over occurs.

Parameters:
WIDTH, 4, counter width in bits (legal range 1..32)
INIT, 0, value loaded on reset (must be less than 2^WIDTH; truncated to WIDTH bits)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous reset, active-high
count  output  WIDTH  current counter value (registered)
tc  output  1  terminal count: high while count == 2^WIDTH-1 (combinational decode of count)
wrap  output  1  registered one-cycle pulse: high in the cycle after count rolls over from 2^WIDTH-1 to 0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; it is sampled only on the rising edge of clk. No asynchronous path.
- Rising edge with reset=1: count <= INIT, wrap <= 0. Reset has priority over counting.
- Rising edge with reset=0: count <= (count + 1) mod 2^WIDTH; wrap <= 1 if the old count == 2^WIDTH-1, else 0.
- Reset values: count = INIT, wrap = 0, tc = (INIT == 2^WIDTH-1).
- Reset held for N edges: count stays INIT for all N edges. The first increment occurs on the first edge where reset=0.
- Reset mid-count: on the next edge count = INIT regardless of the current value; wrap = 0 even if count was at max.
- Latency: count reflects an edge immediately after that edge (one register stage). tc follows count combinationally. wrap is coincident with count == 0 after a roll-over.
- Wrap-around: 2^WIDTH-1 -> 0 with no saturation and no stall. For WIDTH=4 the sequence is 14, 15, 0, 1.
- Before the first reset, count and wrap are undefined (X in simulation). There is no power-on initialisation requirement.
- No enable or load inputs. The counter advances on every non-reset edge.
- Arithmetic is unsigned. The carry out of the MSB is discarded except through wrap.

Test Plan:
- Reset then release (WIDTH=4, INIT=0): reset=1 for 1 edge -> count=0, tc=0, wrap=0. Then reset=0 for 3 edges -> count=1, 2, 3.
- Full roll-over: after reset, run 16 edges -> count goes 1..15 then 0. tc=1 only while count=15. wrap=1 only in the cycle with count=0 after 15, then 0 again.
- Mid-run reset: count 2 edges from 0 (count=2), assert reset for 1 edge -> count=0 and wrap=0. Release -> 1, 2, 3...
- Reset at max: drive count to 15, assert reset -> count=0, wrap stays 0, tc deasserts.
- Long run: 200 time units / ~20 edges free-running after reset -> count = (edges since reset release) mod 16 on every edge, checked against a reference model.
- Parameter variant WIDTH=3, INIT=5: reset -> count=5, then 6, 7, 0 (wrap=1), 1.

Source files
------------

// File: rtl/up_counter_sync.sv
// Free-running WIDTH-bit binary up-counter with synchronous active-high reset.
// Also provides a terminal-count decode (tc) and a registered roll-over pulse (wrap).
module up_counter_sync #(
    parameter int unsigned WIDTH = 4,
    parameter logic [31:0] INIT  = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] INIT_C = INIT[WIDTH-1:0];

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic [WIDTH-1:0] count_next_s;
    logic             carry_s;
    logic             tc_s;

    // Next-count adder; the carry out of the MSB is exactly the roll-over event.
    always_comb begin
        count_next_s = '0;
        carry_s      = 1'b0;
        {carry_s, count_next_s} = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Terminal-count decode of the current registered value.
    always_comb begin
        tc_s = 1'b0;
        if (count_r == MAX_C) begin
            tc_s = 1'b1;
        end else begin
            tc_s = 1'b0;
        end
    end

    // Count and roll-over pulse registers; reset wins over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= INIT_C;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            wrap_r  <= carry_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_s;
    assign wrap  = wrap_r;

endmodule

// File: tb/tb_up_counter_sync.sv
// Self-checking bench for up_counter_sync: WIDTH=4/INIT=0 and WIDTH=3/INIT=5 instances,
// table-driven vectors, hand-written corner sequences and a randomized reset soak.
module tb_up_counter_sync;

    logic       clk = 1'b0;
    logic       reset4 = 1'b1;
    logic       reset3 = 1'b1;
    logic [3:0] count4;
    logic       tc4;
    logic       wrap4;
    logic [2:0] count3;
    logic       tc3;
    logic       wrap3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    up_counter_sync #(.WIDTH(4), .INIT(32'd0)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .count (count4),
        .tc    (tc4),
        .wrap  (wrap4)
    );

    up_counter_sync #(.WIDTH(3), .INIT(32'd5)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .count (count3),
        .tc    (tc3),
        .wrap  (wrap3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input int c, input logic t, input logic w);
        vec_t v;
        v.rst  = r;
        v.cnt  = 4'(c);
        v.tc   = t;
        v.wrap = w;
        return v;
    endfunction

    // Drive resets away from the active edge, then sample just after it.
    task automatic step(input logic r4, input logic r3);
        @(negedge clk);
        reset4 = r4;
        reset3 = r3;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n4;
        int n3;
        int e4;
        int e3;
        logic r4;
        logic r3;

        // Reset then release.
        vecs.push_back(mk(1'b1, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3, 1'b0, 1'b0));
        // Full roll-over after a fresh reset: 1..15, 0 (wrap), 1.
        vecs.push_back(mk(1'b1, 0, 1'b0, 1'b0));
        for (int i = 1; i <= 17; i++) begin
            vecs.push_back(mk(1'b0, i % 16, (i % 16) == 15, i == 16));
        end
        // Mid-run reset at count 2.
        vecs.push_back(mk(1'b0, 2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, 1'b1);
            chk($sformatf("vec%0d_count", i), 32'(count4), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_tc", i),    32'(tc4),    32'(vecs[i].tc));
            chk($sformatf("vec%0d_wrap", i),  32'(wrap4),  32'(vecs[i].wrap));
        end
        // dut3 held in reset the whole time: stays at INIT.
        chk("w3_held_count", 32'(count3), 32'd5);
        chk("w3_held_wrap",  32'(wrap3),  32'd0);

        // Reset at max: reach 15, then reset must clear count and suppress wrap.
        step(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        chk("max_count", 32'(count4), 32'd15);
        chk("max_tc",    32'(tc4),    32'd1);
        step(1'b1, 1'b1);
        chk("rstmax_count", 32'(count4), 32'd0);
        chk("rstmax_wrap",  32'(wrap4),  32'd0);
        chk("rstmax_tc",    32'(tc4),    32'd0);
        step(1'b0, 1'b1);
        chk("rstmax_rel_wrap",  32'(wrap4),  32'd0);
        chk("rstmax_rel_count", 32'(count4), 32'd1);

        // WIDTH=3, INIT=5 variant: 5, 6, 7, 0 (wrap), 1.
        step(1'b1, 1'b1);
        chk("w3_rst_count", 32'(count3), 32'd5);
        chk("w3_rst_tc",    32'(tc3),    32'd0);
        step(1'b1, 1'b0);
        chk("w3_6", 32'(count3), 32'd6);
        step(1'b1, 1'b0);
        chk("w3_7",    32'(count3), 32'd7);
        chk("w3_7_tc", 32'(tc3),    32'd1);
        step(1'b1, 1'b0);
        chk("w3_0",      32'(count3), 32'd0);
        chk("w3_0_wrap", 32'(wrap3),  32'd1);
        chk("w3_0_tc",   32'(tc3),    32'd0);
        step(1'b1, 1'b0);
        chk("w3_1",      32'(count3), 32'd1);
        chk("w3_1_wrap", 32'(wrap3),  32'd0);

        // Random soak: expected value = (INIT + edges since last reset) mod 2^WIDTH.
        n4 = 0;
        n3 = 0;
        for (int i = 0; i < 300; i++) begin
            r4 = (i == 0) || ($urandom_range(0, 11) == 0);
            r3 = (i == 0) || ($urandom_range(0, 11) == 0);
            step(r4, r3);
            n4 = r4 ? 0 : n4 + 1;
            n3 = r3 ? 0 : n3 + 1;
            e4 = n4 % 16;
            e3 = (5 + n3) % 8;
            chk($sformatf("rnd%0d_c4", i), 32'(count4), 32'(e4));
            chk($sformatf("rnd%0d_t4", i), 32'(tc4),    32'(e4 == 15));
            chk($sformatf("rnd%0d_w4", i), 32'(wrap4),  32'((n4 > 0) && (e4 == 0)));
            chk($sformatf("rnd%0d_c3", i), 32'(count3), 32'(e3));
            chk($sformatf("rnd%0d_t3", i), 32'(tc3),    32'(e3 == 7));
            chk($sformatf("rnd%0d_w3", i), 32'(wrap3),  32'((n3 > 0) && (e3 == 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
